mdu_ctrl: RTL and testbench
===========================

Name: mdu_ctrl

Overview:
Multi-cycle multiply/divide sequencer for the EX stage, serving R-type MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO. It owns the HI/LO registers and runs a 32-iteration shift-add multiplier and restoring divider, one bit per cycle. It raises a pipeline stall when a later HI/LO-dependent instruction reaches EX while an operation is in flight.

Parameters:
DATA_SIZE, 32, operand/HI/LO width; iteration count equals DATA_SIZE
FUNC_CODE_SIZE, 6, R-type function code width

Ports:
i_clk  in  1  clock; all state updates on the rising edge
i_reset  in  1  synchronous, active-high reset
i_enable  in  1  pipeline step enable; when low the FSM, counter and HI/LO hold
i_valid  in  1  the instruction in EX is R-type (opcode 0)
i_funct_code  in  FUNC_CODE_SIZE  function code of the EX instruction
i_data_a  in  DATA_SIZE  rs operand (dividend, multiplicand, MTHI/MTLO source)
i_data_b  in  DATA_SIZE  rt operand (divisor, multiplier)
o_busy  out  1  state != IDLE
o_stall  out  1  freeze IF/ID/EX, bubble into MEM
o_result  out  DATA_SIZE  HI for MFHI, LO for MFLO, 0 otherwise
o_hi  out  DATA_SIZE  HI register
o_lo  out  DATA_SIZE  LO register
o_done  out  1  one-cycle pulse when new HI/LO become visible

Behaviour:
- Reset: state=IDLE, HI=LO=0, counter=0, o_busy=0, o_stall=0, o_done=0, o_result=0. Reset also aborts an in-flight operation and wins over i_enable.
- Funct codes: MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B, MFHI 0x10, MTHI 0x11, MFLO 0x12, MTLO 0x13. Any other funct is a non-MDU op.
- An MDU op is i_valid & funct in the set above. A start op is MULT, MULTU, DIV or DIVU.
- States: IDLE, MUL, DIV, FIX.
  - IDLE: on a start op with i_enable=1, do the following, then go to MUL or DIV:
    - latch operand magnitudes; signed ops take the absolute value, unsigned ops pass through;
    - latch the result sign flags: product sign = a XOR b; quotient sign = a XOR b; remainder sign = a;
    - record the divide-by-zero flag (b==0); clear the accumulator; set counter=DATA_SIZE-1.
  - MUL / DIV: one iteration per enabled cycle; counter decrements. At counter==0 the iteration completes and the state goes to FIX.
  - FIX: apply sign correction (two's-complement negate where the flag is set) and write HI/LO, then go to IDLE. FIX lasts one cycle.
- Latency: start op accepted in cycle T. o_busy is high in T+1..T+33 (32 iterations plus FIX). New HI/LO are visible, o_done=1 and o_busy=0 in T+34. Each cycle with i_enable=0 adds one cycle.
- Multiply: 64-bit product; HI = upper half, LO = lower half.
- Divide: LO = quotient, HI = remainder. The remainder takes the sign of the dividend (truncating division).
- Divide by zero (signed or unsigned): same latency; HI = i_data_a as latched, LO = 0xFFFFFFFF, with no sign correction.
- Signed overflow: 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0 (wraps).
- MTHI/MTLO in IDLE with i_enable=1: HI or LO takes i_data_a on the next edge. No busy, no o_done.
- o_stall = o_busy & i_valid & MDU op (combinational). A non-MDU instruction never stalls, so independent instructions proceed during an operation.
- o_result: combinational from the registered HI/LO and the current funct. The value is meaningful only when o_stall=0.
- The instruction that started the operation is not stalled; it advances with no GPR write.
- A start op arriving in the same cycle that FIX completes is stalled in that cycle and accepted in the next cycle (IDLE).

Test Plan:
- MULT a=7, b=0xFFFFFFFD -> o_busy high for exactly 33 cycles, then o_done pulse, HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- DIV 0xFFFFFFF9 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 100 / 7 -> LO=14, HI=2.
- DIVU 5 / 0 -> HI=5, LO=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- MFHI presented at T+5 of a MULT 3x4:
  - o_stall=1 through T+33, and o_stall=0 at T+34 with o_result=0;
  - an ADD funct 0x20 at T+5 gives o_stall=0;
  - MTLO 0x1234 in IDLE gives LO=0x1234 on the next cycle.
- Interruptions:
  - i_enable low for 5 cycles mid-DIVU -> o_done is delayed by exactly 5 cycles, with the correct result;
  - i_reset at iteration 10 -> next cycle o_busy=0, HI=LO=0, o_done never pulses.

Source files
------------

// File: rtl/mdu_ctrl.sv
// EX-stage multiply/divide sequencer owning HI/LO.
// Radix-2 shift-add multiply and restoring divide, one bit per cycle.
module mdu_ctrl #(
  parameter int DATA_SIZE      = 32,
  parameter int FUNC_CODE_SIZE = 6
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_enable,
  input  logic                      i_valid,
  input  logic [FUNC_CODE_SIZE-1:0] i_funct_code,
  input  logic [DATA_SIZE-1:0]      i_data_a,
  input  logic [DATA_SIZE-1:0]      i_data_b,
  output logic                      o_busy,
  output logic                      o_stall,
  output logic [DATA_SIZE-1:0]      o_result,
  output logic [DATA_SIZE-1:0]      o_hi,
  output logic [DATA_SIZE-1:0]      o_lo,
  output logic                      o_done
);

  localparam int W  = DATA_SIZE;
  localparam int CW = $clog2(DATA_SIZE);

  localparam logic [FUNC_CODE_SIZE-1:0] F_MFHI  = FUNC_CODE_SIZE'('h10);
  localparam logic [FUNC_CODE_SIZE-1:0] F_MTHI  = FUNC_CODE_SIZE'('h11);
  localparam logic [FUNC_CODE_SIZE-1:0] F_MFLO  = FUNC_CODE_SIZE'('h12);
  localparam logic [FUNC_CODE_SIZE-1:0] F_MTLO  = FUNC_CODE_SIZE'('h13);
  localparam logic [FUNC_CODE_SIZE-1:0] F_MULT  = FUNC_CODE_SIZE'('h18);
  localparam logic [FUNC_CODE_SIZE-1:0] F_MULTU = FUNC_CODE_SIZE'('h19);
  localparam logic [FUNC_CODE_SIZE-1:0] F_DIV   = FUNC_CODE_SIZE'('h1A);
  localparam logic [FUNC_CODE_SIZE-1:0] F_DIVU  = FUNC_CODE_SIZE'('h1B);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [2*W-1:0]  acc;
  logic [W-1:0]    mag;
  logic            neg_q;
  logic            neg_r;
  logic            dz;
  logic            div_mode;
  logic [W-1:0]    hi;
  logic [W-1:0]    lo;
  logic            done;

  logic is_start, is_signed, is_div_op;
  logic is_mfhi, is_mflo, is_mthi, is_mtlo;
  logic mdu_op;

  always_comb begin
    is_start  = 1'b0;
    is_signed = 1'b0;
    is_div_op = 1'b0;
    is_mfhi   = 1'b0;
    is_mflo   = 1'b0;
    is_mthi   = 1'b0;
    is_mtlo   = 1'b0;
    unique case (i_funct_code)
      F_MULT: begin
        is_start  = 1'b1;
        is_signed = 1'b1;
      end
      F_MULTU: is_start = 1'b1;
      F_DIV: begin
        is_start  = 1'b1;
        is_signed = 1'b1;
        is_div_op = 1'b1;
      end
      F_DIVU: begin
        is_start  = 1'b1;
        is_div_op = 1'b1;
      end
      F_MFHI: is_mfhi = 1'b1;
      F_MFLO: is_mflo = 1'b1;
      F_MTHI: is_mthi = 1'b1;
      F_MTLO: is_mtlo = 1'b1;
      default: ;
    endcase
  end

  assign mdu_op = i_valid &
    (is_start | is_mfhi | is_mflo | is_mthi | is_mtlo);

  logic          a_neg, b_neg;
  logic [W-1:0]  a_mag, b_mag;

  assign a_neg = is_signed & i_data_a[W-1];
  assign b_neg = is_signed & i_data_b[W-1];
  assign a_mag = a_neg ? -i_data_a : i_data_a;
  assign b_mag = b_neg ? -i_data_b : i_data_b;

  // Multiply: acc = {partial, multiplier}, shifted right each step.
  logic [W:0]     mul_sum;
  logic [2*W-1:0] mul_next;

  assign mul_sum  = {1'b0, acc[2*W-1:W]} +
                    (acc[0] ? {1'b0, mag} : '0);
  assign mul_next = {mul_sum, acc[W-1:1]};

  // Divide: acc = {remainder, dividend/quotient}.
  logic [W:0]     div_shift;
  logic [W+1:0]   div_diff;
  logic           div_ok;
  logic [2*W-1:0] div_next;

  assign div_shift = {acc[2*W-1:W], acc[W-1]};
  assign div_diff  = {1'b0, div_shift} - {2'b00, mag};
  assign div_ok    = ~div_diff[W+1];
  assign div_next  = {div_ok ? div_diff[W-1:0] : div_shift[W-1:0],
                      acc[W-2:0], div_ok};

  logic [2*W-1:0] prod_fix;
  logic [W-1:0]   rem_fix;
  logic [W-1:0]   quo_fix;

  assign prod_fix = neg_q ? -acc : acc;
  assign rem_fix  = neg_r ? -acc[2*W-1:W] : acc[2*W-1:W];
  assign quo_fix  = dz ? '1 : (neg_q ? -acc[W-1:0] : acc[W-1:0]);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      acc      <= '0;
      mag      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      dz       <= 1'b0;
      div_mode <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (i_enable) begin
        unique case (state)
          S_IDLE: begin
            if (i_valid && is_start) begin
              neg_q    <= a_neg ^ b_neg;
              neg_r    <= a_neg;
              dz       <= is_div_op && (i_data_b == '0);
              div_mode <= is_div_op;
              cnt      <= CW'(DATA_SIZE - 1);
              if (is_div_op) begin
                acc   <= {{W{1'b0}}, a_mag};
                mag   <= b_mag;
                state <= S_DIV;
              end else begin
                acc   <= {{W{1'b0}}, b_mag};
                mag   <= a_mag;
                state <= S_MUL;
              end
            end else if (i_valid && is_mthi) begin
              hi <= i_data_a;
            end else if (i_valid && is_mtlo) begin
              lo <= i_data_a;
            end
          end
          S_MUL: begin
            acc <= mul_next;
            cnt <= cnt - 1'b1;
            if (cnt == '0) state <= S_FIX;
          end
          S_DIV: begin
            acc <= div_next;
            cnt <= cnt - 1'b1;
            if (cnt == '0) state <= S_FIX;
          end
          S_FIX: begin
            if (div_mode) begin
              hi <= rem_fix;
              lo <= quo_fix;
            end else begin
              {hi, lo} <= prod_fix;
            end
            done  <= 1'b1;
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign o_busy   = (state != S_IDLE);
  assign o_stall  = o_busy & mdu_op;
  assign o_hi     = hi;
  assign o_lo     = lo;
  assign o_done   = done;
  assign o_result = (i_valid && is_mfhi) ? hi :
                    (i_valid && is_mflo) ? lo : '0;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: stimulus pushes expected {HI,LO},
// a monitor pops and compares on every o_done pulse.
module tb_mdu_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b1;
  logic        valid = 1'b0;
  logic [5:0]  funct = 6'h20;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, stall, done;
  logic [31:0] result, hi, lo;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];

  mdu_ctrl #(.DATA_SIZE(32), .FUNC_CODE_SIZE(6)) dut (
    .i_clk(clk),
    .i_reset(rst),
    .i_enable(en),
    .i_valid(valid),
    .i_funct_code(funct),
    .i_data_a(a),
    .i_data_b(b),
    .o_busy(busy),
    .o_stall(stall),
    .o_result(result),
    .o_hi(hi),
    .o_lo(lo),
    .o_done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=1 required=0");
      end else begin
        check("hi_lo", {hi, lo}, exp_q.pop_front());
      end
    end
  end

  task automatic run_op(input string name, input logic [5:0] f,
                        input logic [31:0] da, input logic [31:0] db,
                        input logic [63:0] e, input int gap_at,
                        input int gap_len, input int exp_busy);
    int n;
    @(negedge clk);
    valid = 1'b1;
    funct = f;
    a = da;
    b = db;
    exp_q.push_back(e);
    @(negedge clk);
    valid = 1'b0;
    funct = 6'h20;
    n = 0;
    while (busy && n < 200) begin
      n++;
      if (gap_at != 0 && n == gap_at) en = 1'b0;
      if (gap_at != 0 && n == gap_at + gap_len) en = 1'b1;
      @(negedge clk);
    end
    en = 1'b1;
    check({name, "_busy_cycles"}, 64'(n), 64'(exp_busy));
    check({name, "_done"}, 64'(done), 64'(1));
  endtask

  initial begin
    int n;
    valid = 1'b1;
    funct = 6'h10;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_stall", 64'(stall), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_hi", 64'(hi), 64'(0));
    check("rst_lo", 64'(lo), 64'(0));
    check("rst_result", 64'(result), 64'(0));
    valid = 1'b0;
    funct = 6'h20;

    run_op("mult_neg", 6'h18, 32'd7, 32'hFFFFFFFD,
           64'hFFFFFFFF_FFFFFFEB, 0, 0, 33);
    run_op("multu_max", 6'h19, 32'hFFFFFFFF, 32'hFFFFFFFF,
           64'hFFFFFFFE_00000001, 0, 0, 33);
    run_op("div_neg", 6'h1A, 32'hFFFFFFF9, 32'd2,
           64'hFFFFFFFF_FFFFFFFD, 0, 0, 33);
    run_op("div_negb", 6'h1A, 32'd7, 32'hFFFFFFFE,
           64'h00000001_FFFFFFFD, 0, 0, 33);
    run_op("divu", 6'h1B, 32'd100, 32'd7,
           64'h00000002_0000000E, 0, 0, 33);
    run_op("divu_zero", 6'h1B, 32'd5, 32'd0,
           64'h00000005_FFFFFFFF, 0, 0, 33);
    run_op("div_zero", 6'h1A, 32'hFFFFFFF9, 32'd0,
           64'hFFFFFFF9_FFFFFFFF, 0, 0, 33);
    run_op("div_ovf", 6'h1A, 32'h80000000, 32'hFFFFFFFF,
           64'h00000000_80000000, 0, 0, 33);

    // Dependent MFHI stalls; independent ADD flows.
    @(negedge clk);
    valid = 1'b1; funct = 6'h18; a = 32'd3; b = 32'd4;
    exp_q.push_back(64'h00000000_0000000C);
    @(negedge clk);
    valid = 1'b0; funct = 6'h20;
    @(negedge clk);
    @(negedge clk);
    valid = 1'b1; funct = 6'h20;
    #1 check("add_no_stall", 64'(stall), 64'(0));
    @(negedge clk);
    valid = 1'b0;
    @(negedge clk);
    valid = 1'b1; funct = 6'h10;
    #1;
    n = 0;
    while (stall && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("mfhi_stall_cycles", 64'(n), 64'(29));
    check("mfhi_release", 64'(stall), 64'(0));
    check("mfhi_result", 64'(result), 64'(0));
    check("mfhi_done", 64'(done), 64'(1));
    funct = 6'h12;
    #1 check("mflo_result", 64'(result), 64'(12));
    @(negedge clk);
    funct = 6'h13; a = 32'h1234;
    @(negedge clk);
    valid = 1'b0; funct = 6'h20;
    check("mtlo_lo", 64'(lo), 64'(32'h1234));
    check("mtlo_busy", 64'(busy), 64'(0));

    // Start op arriving during FIX is held one cycle.
    @(negedge clk);
    valid = 1'b1; funct = 6'h18; a = 32'd2; b = 32'd3;
    exp_q.push_back(64'h00000000_00000006);
    @(negedge clk);
    valid = 1'b0; funct = 6'h20;
    repeat (32) @(negedge clk);
    valid = 1'b1; funct = 6'h1B; a = 32'd9; b = 32'd4;
    exp_q.push_back(64'h00000001_00000002);
    #1 check("fix_stall", 64'(stall), 64'(1));
    @(negedge clk);
    check("idle_accept_stall", 64'(stall), 64'(0));
    @(negedge clk);
    valid = 1'b0; funct = 6'h20;
    n = 0;
    while (busy && n < 200) begin
      n++;
      @(negedge clk);
    end
    check("back2back_busy_cycles", 64'(n), 64'(33));

    run_op("divu_gap", 6'h1B, 32'd100, 32'd7,
           64'h00000002_0000000E, 10, 5, 38);

    // Reset aborts an operation mid-flight.
    @(negedge clk);
    valid = 1'b1; funct = 6'h18; a = 32'd3; b = 32'd4;
    @(negedge clk);
    valid = 1'b0; funct = 6'h20;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_hi", 64'(hi), 64'(0));
    check("abort_lo", 64'(lo), 64'(0));
    repeat (40) @(negedge clk);

    check("queue_empty", 64'(exp_q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
